mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-port CPU-to-RAM access sequencer with load timeout
//   clk, clr                : clock, asynchronous active-high reset
//   req, we, cpuAddr,
//   cpuWriteData            : CPU request (store when we=1, load otherwise)
//   reqReady, done, err,
//   cpuReadData             : idle flag, completion pulse, load timeout flag, load result
//   ramWriteEnable, ramAddr,
//   ramWriteData            : RAM write port
//   ramReadEnable,
//   ramReadAddr             : RAM read port request
//   ramDataReady,
//   ramReadData             : RAM read port response
module mem_access_ctrl #(
  parameter int width   = 16,
  parameter int length  = 8,
  parameter int timeout = 15
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [length-1:0] cpuAddr,
  input  logic [width-1:0]  cpuWriteData,
  output logic              reqReady,
  output logic              done,
  output logic              err,
  output logic [width-1:0]  cpuReadData,
  output logic              ramWriteEnable,
  output logic              ramReadEnable,
  output logic [length-1:0] ramAddr,
  output logic [length-1:0] ramReadAddr,
  output logic [width-1:0]  ramWriteData,
  input  logic              ramDataReady,
  input  logic [width-1:0]  ramReadData
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WRITE   = 3'd1;
  localparam logic [2:0] READ    = 3'd2;
  localparam logic [2:0] WAIT    = 3'd3;
  localparam logic [2:0] CAPTURE = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [width-1:0]  rdata_q, rdata_d;
  logic [width-1:0]  wdata_q, wdata_d;
  logic [length-1:0] waddr_q, waddr_d;
  logic [length-1:0] raddr_q, raddr_d;

  // Write and read address registers are separate so each port holds its
  // last strobed address while the other kind of access runs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    waddr_d = waddr_q;
    raddr_d = raddr_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = we ? WRITE : READ;
        waddr_d = we ? cpuAddr : waddr_q;
        wdata_d = we ? cpuWriteData : wdata_q;
        raddr_d = we ? raddr_q : cpuAddr;
      end
      WRITE: state_d = DONE;
      READ: begin
        cnt_d   = 8'd0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        // Ready on the final counted cycle still wins over the timeout.
        if (ramDataReady) state_d = CAPTURE;
        else if (cnt_d == 8'(timeout)) begin
          state_d = DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      // Data is sampled one cycle after ready to tolerate RAM output delay.
      CAPTURE: begin
        rdata_d = ramReadData;
        err_d   = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      raddr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      raddr_q <= raddr_d;
    end
  end

  assign reqReady       = state_q == IDLE;
  assign done           = state_q == DONE;
  assign ramWriteEnable = state_q == WRITE;
  assign ramReadEnable  = (state_q == READ) || (state_q == WAIT);
  assign err            = err_q;
  assign cpuReadData    = rdata_q;
  assign ramAddr        = waddr_q;
  assign ramWriteData   = wdata_q;
  assign ramReadAddr    = raddr_q;
endmodule
